// File: rtl/npc_unit_if.sv
// npc_unit_if: next-PC control inputs and PC outputs shared by IF-stage logic and the PC unit
interface npc_unit_if #(parameter int WIDTH = 32);
  logic             stall;
  logic [1:0]       npc_sel;
  logic             branch_taken;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] jr_target;
  logic             exc_req;
  logic             eret_req;
  logic [WIDTH-1:0] epc;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc4;
  logic             redirect_pending;
  logic             jr_misalign;
  modport master (
    output stall, npc_sel, branch_taken, jump_target, jr_target, exc_req, eret_req, epc,
    input  pc, pc4, redirect_pending, jr_misalign
  );
  modport slave (
    input  stall, npc_sel, branch_taken, jump_target, jr_target, exc_req, eret_req, epc,
    output pc, pc4, redirect_pending, jr_misalign
  );
endinterface

// File: rtl/npc_unit.sv
// npc_unit: IF-stage program counter with stall-aware redirect latching
module npc_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(32'h0000_4180),
  parameter int               STEP     = 4
) (
  input  logic      clk,
  input  logic      reset,
  npc_unit_if.slave bus
);
  typedef enum logic {RUN, HOLD} state_t;
  state_t           state;
  logic [WIDTH-1:0] pend_target;
  logic             redirect;
  logic             jr_bad;
  logic [WIDTH-1:0] target;
  assign redirect = (bus.npc_sel == 2'd1) || (bus.npc_sel == 2'd2 && bus.branch_taken) || (bus.npc_sel == 2'd3);
  assign target   = (bus.npc_sel == 2'd3) ? bus.jr_target : bus.jump_target;
  assign jr_bad   = (bus.npc_sel == 2'd3) && (bus.jr_target[1:0] != 2'b00);
  assign bus.pc4  = bus.pc + WIDTH'(STEP);
  assign bus.redirect_pending = (state == HOLD);
  // While holding, the first latched redirect wins; later ones are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pc          <= RESET_PC;
      state           <= RUN;
      pend_target     <= '0;
      bus.jr_misalign <= 1'b0;
    end else begin
      bus.jr_misalign <= 1'b0;
      if (bus.exc_req) begin
        bus.pc <= EXC_VEC;
        state  <= RUN;
      end else if (bus.eret_req) begin
        bus.pc <= bus.epc;
        state  <= RUN;
      end else if (state == HOLD) begin
        if (!bus.stall) begin
          bus.pc <= pend_target;
          state  <= RUN;
        end
      end else begin
        bus.jr_misalign <= jr_bad;
        if (bus.stall && redirect) begin
          pend_target <= target;
          state       <= HOLD;
        end else if (!bus.stall) begin
          bus.pc <= redirect ? target : bus.pc4;
        end
      end
    end
  end
endmodule

// File: tb/tb_npc_unit.sv
// tb_npc_unit: directed and random stimulus against a queue-based PC reference model
module tb_npc_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  npc_unit_if #(.WIDTH(32)) bus ();
  npc_unit dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic        mis;
  } exp_t;
  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_tgt = 32'h0;
  logic        m_hold = 1'b0;
  bit          done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Architectural model: what the PC must be after the edge, by the priority rules.
  task automatic step(input logic rs, input logic st, input logic [1:0] sel, input logic tk,
                      input logic [31:0] jt, input logic [31:0] jrt,
                      input logic ex, input logic er, input logic [31:0] e);
    bit redir;
    logic [31:0] tgt;
    logic mis;
    @(negedge clk);
    reset = rs; bus.stall = st; bus.npc_sel = sel; bus.branch_taken = tk;
    bus.jump_target = jt; bus.jr_target = jrt; bus.exc_req = ex; bus.eret_req = er; bus.epc = e;
    redir = (sel == 2'd1) || (sel == 2'd3) || (sel == 2'd2 && tk);
    tgt = (sel == 2'd3) ? jrt : jt;
    mis = 1'b0;
    if (rs) begin
      m_pc = 32'h3000; m_hold = 1'b0;
    end else if (ex) begin
      m_pc = 32'h4180; m_hold = 1'b0;
    end else if (er) begin
      m_pc = e; m_hold = 1'b0;
    end else if (m_hold) begin
      if (!st) begin m_pc = m_tgt; m_hold = 1'b0; end
    end else begin
      mis = (sel == 2'd3) && (jrt % 4 != 0);
      if (st && redir) begin m_tgt = tgt; m_hold = 1'b1; end
      else if (!st) m_pc = redir ? tgt : m_pc + 32'd4;
    end
    q.push_back('{pc: m_pc, pend: m_hold, mis: mis});
  endtask

  task automatic seq(input logic st, input logic [1:0] sel, input logic tk,
                     input logic [31:0] jt, input logic [31:0] jrt);
    step(1'b0, st, sel, tk, jt, jrt, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("pc", bus.pc, x.pc);
        check("pc4", bus.pc4, x.pc + 32'd4);
        check("redirect_pending", {31'b0, bus.redirect_pending}, {31'b0, x.pend});
        check("jr_misalign", {31'b0, bus.jr_misalign}, {31'b0, x.mis});
      end
    end
  end

  initial begin : stim
    reset = 1'b1; bus.stall = 1'b0; bus.npc_sel = 2'd0; bus.branch_taken = 1'b0;
    bus.jump_target = '0; bus.jr_target = '0; bus.exc_req = 1'b0; bus.eret_req = 1'b0; bus.epc = '0;
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    seq(0, 2'd0, 0, 0, 0);
    seq(0, 2'd0, 0, 0, 0);
    seq(0, 2'd2, 0, 32'h3100, 0);
    seq(0, 2'd2, 1, 32'h3100, 0);
    seq(1, 2'd1, 0, 32'h3400, 0);
    seq(1, 2'd3, 0, 0, 32'h5000);
    seq(1, 2'd0, 0, 0, 0);
    seq(0, 2'd3, 0, 0, 32'h5000);
    seq(0, 2'd0, 0, 0, 0);
    seq(1, 2'd1, 0, 32'h3800, 0);
    step(1'b0, 1, 2'd1, 0, 32'h3900, 0, 1'b1, 1'b0, 0);
    step(1'b0, 0, 2'd0, 0, 0, 0, 1'b0, 1'b1, 32'h3008);
    seq(0, 2'd3, 0, 0, 32'h3002);
    seq(0, 2'd0, 0, 0, 0);
    seq(1, 2'd3, 0, 0, 32'h6001);
    seq(0, 2'd0, 0, 0, 0);
    seq(1, 2'd1, 0, 32'h3c00, 0);
    step(1'b1, 1, 2'd1, 0, 32'h3d00, 0, 0, 0, 0);
    seq(0, 2'd1, 0, 32'hFFFF_FFFC, 0);
    seq(0, 2'd0, 0, 0, 0);
    seq(0, 2'd0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] jt, jrt, e;
      jt = $urandom; jrt = $urandom; e = $urandom;
      if ($urandom_range(0, 3) != 0) jrt[1:0] = 2'b00;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), jt, jrt, $urandom_range(0, 19) == 0,
           $urandom_range(0, 19) == 0, e);
    end
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
